// File: rtl/gray_stream_if.sv
// Frame-FIFO pop side and Gray-coded beat stream of gray_stream_serializer.
// master = serializer side, slave = FIFO/downstream side.
interface gray_stream_if #(
    parameter int SLICE_W    = 16,
    parameter int MAX_SLICES = 8,
    parameter int CH_W       = 8,
    parameter int LEN_W      = 4
);
    localparam int FIFO_W = MAX_SLICES * SLICE_W + CH_W + LEN_W;

    logic              fifo_empty;
    logic              fifo_rd;
    logic [FIFO_W-1:0] data_from_fifo;
    logic              dout_vld;
    logic              dout_rdy;
    logic [SLICE_W-1:0] dout;
    logic [CH_W-1:0]   dout_ch;
    logic [15:0]       dout_count;
    logic              dout_last;

    modport master (
        input  fifo_empty, data_from_fifo, dout_rdy,
        output fifo_rd, dout_vld, dout, dout_ch, dout_count, dout_last
    );

    modport slave (
        output fifo_empty, data_from_fifo, dout_rdy,
        input  fifo_rd, dout_vld, dout, dout_ch, dout_count, dout_last
    );
endinterface

// File: rtl/gray_stream_serializer.sv
// Pops frame words {payload, ch, len} and streams the Gray-coded payload MSB-first in SLICE_W beats.
// Optional GRAY_ERR_FLAG_EN adds the err_len pulse for dropped (bad-length) frames.
//
// state | meaning
// IDLE  | waiting for a frame; pop strobe issued from here
// FETCH | frame word on data_from_fifo; capture and validate length
// SEND  | presenting beats until the last one is accepted
module gray_stream_serializer #(
    parameter int SLICE_W    = 16,
    parameter int MAX_SLICES = 8,
    parameter int CH_W       = 8,
    parameter int LEN_W      = 4
) (
    input  logic clk,
    input  logic rst,
    gray_stream_if.master bus
`ifdef GRAY_ERR_FLAG_EN
    ,
    output logic err_len
`endif
);
    localparam int PAY_W  = MAX_SLICES * SLICE_W;
    localparam int FIFO_W = PAY_W + CH_W + LEN_W;
    localparam int SHIFT  = $clog2(SLICE_W);
    localparam logic [LEN_W:0]   MAX_LEN = (LEN_W + 1)'(MAX_SLICES);
    localparam logic [LEN_W-1:0] ONE     = (LEN_W)'(1);

    typedef enum logic [1:0] {IDLE, FETCH, SEND} state_t;

    state_t state, next_state;

    logic [PAY_W-1:0]   shreg;
    logic [CH_W-1:0]    ch_q;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   beat_cnt;
    logic               carry;
    logic               fifo_rd_q;
    logic               fifo_rd_d;

    logic [PAY_W-1:0]   payload_in;
    logic [CH_W-1:0]    ch_in;
    logic [LEN_W-1:0]   len_in;
    logic               len_bad;
    logic               sending;
    logic               beat_take;
    logic [SLICE_W-1:0] top_slice;
    logic [LEN_W+SHIFT-1:0] bits_full;
    logic [15:0]        bits16;

    assign payload_in = bus.data_from_fifo[FIFO_W-1 -: PAY_W];
    assign ch_in      = bus.data_from_fifo[LEN_W +: CH_W];
    assign len_in     = bus.data_from_fifo[LEN_W-1:0];
    assign len_bad    = (len_in == '0) || ({1'b0, len_in} > MAX_LEN);

    assign sending   = (state == SEND);
    assign beat_take = sending && bus.dout_rdy;
    assign top_slice = shreg[PAY_W-1 -: SLICE_W];

    // Frame length in bits; SLICE_W is a power of two so this is a plain shift.
    assign bits_full = {len_q, {SHIFT{1'b0}}};
    generate
        if (LEN_W + SHIFT >= 16) begin : g_count_trunc
            assign bits16 = bits_full[15:0];
        end else begin : g_count_ext
            assign bits16 = {{(16 - LEN_W - SHIFT){1'b0}}, bits_full};
        end
    endgenerate

    always_comb begin
        next_state = state;
        fifo_rd_d  = 1'b0;
        case (state)
            IDLE:    if (fifo_rd_q) next_state = FETCH;
            FETCH:   next_state = len_bad ? IDLE : SEND;
            SEND:    if (beat_take && (beat_cnt == '0)) next_state = IDLE;
            default: next_state = IDLE;
        endcase
        // The pop is registered, so it is decided on the cycle that enters IDLE.
        fifo_rd_d = (next_state == IDLE) && !bus.fifo_empty;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            fifo_rd_q <= 1'b0;
            shreg     <= '0;
            ch_q      <= '0;
            len_q     <= '0;
            beat_cnt  <= '0;
            carry     <= 1'b0;
        end else begin
            state     <= next_state;
            fifo_rd_q <= fifo_rd_d;
            if (state == FETCH) begin
                shreg    <= payload_in;
                ch_q     <= ch_in;
                len_q    <= len_in;
                beat_cnt <= len_in - ONE;
                carry    <= 1'b0;
            end else if (beat_take) begin
                shreg    <= shreg << SLICE_W;
                carry    <= top_slice[0];
                beat_cnt <= beat_cnt - ONE;
            end
        end
    end

`ifdef GRAY_ERR_FLAG_EN
    // Registered so the flag has no input-to-output path; it lands on the cycle after FETCH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_len <= 1'b0;
        else     err_len <= (state == FETCH) && len_bad;
    end
`endif

    assign bus.fifo_rd    = fifo_rd_q;
    assign bus.dout_vld   = sending;
    assign bus.dout_last  = sending && (beat_cnt == '0);
    assign bus.dout       = sending ? (top_slice ^ {carry, top_slice[SLICE_W-1:1]}) : '0;
    assign bus.dout_ch    = sending ? ch_q : '0;
    assign bus.dout_count = sending ? bits16 : '0;
endmodule

// File: tb/tb_gray_stream_serializer.sv
// Randomized bench for gray_stream_serializer: a queue-based FIFO feeds frames and a
// whole-frame Gray-code model predicts every beat, checked on each falling edge.
module tb_gray_stream_serializer;
    localparam int SLICE_W    = 16;
    localparam int MAX_SLICES = 8;
    localparam int CH_W       = 8;
    localparam int LEN_W      = 4;
    localparam int PAY_W      = MAX_SLICES * SLICE_W;
    localparam int FIFO_W     = PAY_W + CH_W + LEN_W;

    typedef logic [FIFO_W-1:0] word_t;
    typedef struct {
        logic [SLICE_W-1:0] data;
        logic [CH_W-1:0]    ch;
        logic [15:0]        count;
        logic               last;
        logic               first;
        int                 t_rd;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    gray_stream_if #(.SLICE_W(SLICE_W), .MAX_SLICES(MAX_SLICES), .CH_W(CH_W), .LEN_W(LEN_W)) bus ();

`ifdef GRAY_ERR_FLAG_EN
    logic err_len;
    gray_stream_serializer #(.SLICE_W(SLICE_W), .MAX_SLICES(MAX_SLICES), .CH_W(CH_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .bus(bus), .err_len(err_len));
`else
    gray_stream_serializer #(.SLICE_W(SLICE_W), .MAX_SLICES(MAX_SLICES), .CH_W(CH_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .bus(bus));
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pushes = 0, pops = 0, drops = 0;
    int beats_exp = 0, beats_acc = 0;
    int rdy_mode = 1;
    logic rdy_val = 1'b1;
    word_t fifo_q[$];
    beat_t exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int frame_len(input word_t w);
        int len;
        len = int'(w[LEN_W-1:0]);
        if (len == 0 || len > MAX_SLICES) return 0;
        return len;
    endfunction

    function automatic logic [PAY_W-1:0] frame_gray(input word_t w);
        logic [PAY_W-1:0] p;
        int nb;
        nb = frame_len(w) * SLICE_W;
        p = w[FIFO_W-1 -: PAY_W] >> (PAY_W - nb);
        return p ^ (p >> 1);
    endfunction

    function automatic logic [SLICE_W-1:0] beat_of(input word_t w, input int i);
        logic [PAY_W-1:0] g;
        g = frame_gray(w);
        return SLICE_W'(g >> ((frame_len(w) - 1 - i) * SLICE_W));
    endfunction

    function automatic logic [15:0] count_of(input word_t w);
        return 16'(int'(w[LEN_W-1:0]) * SLICE_W);
    endfunction

    function automatic word_t mk(input logic [PAY_W-1:0] pay, input logic [CH_W-1:0] ch, input logic [LEN_W-1:0] len);
        return {pay, ch, len};
    endfunction

    // ---------------- upstream FIFO ----------------
    word_t popped;
    int    n_beats;
    beat_t nb_e;
    always @(negedge clk) begin
        if (bus.fifo_rd) begin
            check("fifo_rd_nonempty", 128'(fifo_q.size() != 0), 128'd1);
            if (fifo_q.size() != 0) begin
                popped = fifo_q.pop_front();
                pops++;
                bus.data_from_fifo = popped;
                n_beats = frame_len(popped);
                if (n_beats == 0) drops++;
                for (int i = 0; i < n_beats; i++) begin
                    nb_e.data  = beat_of(popped, i);
                    nb_e.ch    = popped[LEN_W +: CH_W];
                    nb_e.count = count_of(popped);
                    nb_e.last  = (i == n_beats - 1);
                    nb_e.first = (i == 0);
                    nb_e.t_rd  = cyc;
                    exp_q.push_back(nb_e);
                    beats_exp++;
                end
            end
        end
        bus.fifo_empty = (fifo_q.size() == 0);
    end

    // ---------------- downstream ready ----------------
    initial begin
        bus.dout_rdy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.dout_rdy = (rdy_mode != 0) ? rdy_val : ($urandom_range(0, 3) != 0);
        end
    end

    // ---------------- output compare ----------------
    beat_t e;
    logic prev_vld = 1'b0, prev_acc = 1'b0, prev_last = 1'b0;
    logic [SLICE_W-1:0] prev_dout = '0;
    always @(negedge clk) begin
        if (rst) begin
            prev_vld = 1'b0;
            prev_acc = 1'b0;
        end else begin
            check("rd_while_vld", 128'(bus.fifo_rd && bus.dout_vld), 128'd0);
            if (bus.dout_vld) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 128'(bus.dout), 128'hDEAD_0000);
                end else begin
                    e = exp_q[0];
                    check("dout", 128'(bus.dout), 128'(e.data));
                    check("dout_ch", 128'(bus.dout_ch), 128'(e.ch));
                    check("dout_count", 128'(bus.dout_count), 128'(e.count));
                    check("dout_last", 128'(bus.dout_last), 128'(e.last));
                    if (prev_vld && !prev_acc)
                        check("hold_stable", 128'(bus.dout), 128'(prev_dout));
                    else if (e.first)
                        check("first_beat_latency", 128'(cyc - e.t_rd), 128'd2);
                    if (bus.dout_rdy) begin
                        void'(exp_q.pop_front());
                        beats_acc++;
                    end
                end
            end else begin
                check("idle_outputs", {bus.dout_ch, bus.dout_count, bus.dout_last}, 128'd0);
                if (prev_vld)
                    check("vld_midframe_drop", 128'(prev_acc && prev_last), 128'd1);
            end
            prev_vld  = bus.dout_vld;
            prev_acc  = bus.dout_vld && bus.dout_rdy;
            prev_last = bus.dout_last;
            prev_dout = bus.dout;
        end
    end

`ifdef GRAY_ERR_FLAG_EN
    int err_seen = 0;
    always @(negedge clk) if (!rst && err_len) err_seen++;
`endif

    // ---------------- stimulus ----------------
    task automatic push(input word_t w);
        @(posedge clk);
        #2;
        fifo_q.push_back(w);
        pushes++;
    endtask

    task automatic drain(input int max);
        int k;
        k = 0;
        while ((fifo_q.size() != 0 || exp_q.size() != 0 || bus.dout_vld) && k < max) begin
            @(negedge clk);
            k++;
        end
        check("drain_timeout", 128'(k < max), 128'd1);
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_vld(input int max);
        int k;
        k = 0;
        while (!bus.dout_vld && k < max) begin
            @(negedge clk);
            k++;
        end
        check("wait_vld_timeout", 128'(k < max), 128'd1);
    endtask

    initial begin
        word_t w1, w2, w3, w9, w0, wst, wr;
        logic [PAY_W-1:0] pay;
        int rd_cnt;

        w1  = mk({16'hFFFF, 112'h0}, 8'h01, 4'd1);
        w2  = mk({32'h0001_8000, 96'h0}, 8'h02, 4'd2);
        w3  = mk({PAY_W{1'b1}}, 8'h80, 4'd8);
        w9  = mk({PAY_W{1'b1}}, 8'h04, 4'd9);
        w0  = mk({PAY_W{1'b1}}, 8'h08, 4'd0);
        wst = mk({48'h0000_FFFF_0000, 80'h0}, 8'h10, 4'd3);

        // model pinned against hand-computed values
        check("pin_len1_beat", 128'(beat_of(w1, 0)), 128'h8000);
        check("pin_len1_count", 128'(count_of(w1)), 128'd16);
        check("pin_len2_beat0", 128'(beat_of(w2, 0)), 128'h0001);
        check("pin_len2_beat1", 128'(beat_of(w2, 1)), 128'h4000);
        check("pin_len2_count", 128'(count_of(w2)), 128'd32);
        check("pin_len8_beat0", 128'(beat_of(w3, 0)), 128'h8000);
        check("pin_len8_beat7", 128'(beat_of(w3, 7)), 128'h0000);
        check("pin_len8_count", 128'(count_of(w3)), 128'd128);
        check("pin_len9_drop", 128'(frame_len(w9)), 128'd0);
        check("pin_len0_drop", 128'(frame_len(w0)), 128'd0);
        check("pin_stall_beat1", 128'(beat_of(wst, 1)), 128'h8000);

        #23;
        check("reset_outputs", {bus.fifo_rd, bus.dout_vld, bus.dout, bus.dout_ch, bus.dout_count, bus.dout_last}, 128'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        rdy_mode = 1;
        rdy_val  = 1'b1;
        push(w1); drain(100);
        push(w2); drain(100);
        push(w3); drain(100);
        push(w9); push(w0); push(w1); drain(100);
        check("bad_len_drops", 128'(drops), 128'd2);

        // beat 2 of a len=3 frame stalled for three cycles
        push(wst);
        wait_vld(50);
        rdy_val = 1'b0;
        @(negedge clk);
        check("stall_beat2_c1", 128'(bus.dout), 128'h8000);
        @(negedge clk);
        @(negedge clk);
        check("stall_beat2_c3", 128'(bus.dout), 128'h8000);
        rdy_val = 1'b1;
        drain(100);

        // randomized frames and backpressure
        rdy_mode = 0;
        for (int f = 0; f < 40; f++) begin
            for (int k = 0; k < PAY_W / 32; k++) pay[k*32 +: 32] = $urandom;
            push(mk(pay, 8'(1 << $urandom_range(0, 7)), 4'($urandom_range(0, 10))));
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end
        drain(4000);
        check("pops_eq_pushes", 128'(pops), 128'(pushes));
        check("beats_all_accepted", 128'(beats_acc), 128'(beats_exp));
`ifdef GRAY_ERR_FLAG_EN
        check("err_len_pulses", 128'(err_seen), 128'(drops));
`endif

        // reset during beat 2 of a len=4 frame
        rdy_mode = 1;
        rdy_val  = 1'b1;
        for (int k = 0; k < PAY_W / 32; k++) pay[k*32 +: 32] = $urandom;
        wr = mk(pay, 8'h20, 4'd4);
        push(wr);
        wait_vld(50);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midframe_reset_outputs", {bus.fifo_rd, bus.dout_vld, bus.dout, bus.dout_ch, bus.dout_count, bus.dout_last}, 128'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rd_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus.fifo_rd || bus.dout_vld) rd_cnt++;
        end
        check("post_reset_quiet", 128'(rd_cnt), 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got time %0t expected completion", $time);
        $fatal(1, "timeout");
    end
endmodule
